// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit sequencer: PIDs, request codes,
// SYNC pattern, CRC16 parameters and the sequencer state encoding.
package usb_tx_pkg;

  typedef enum logic [3:0] {
    PID_ACK   = 4'h2,
    PID_DATA0 = 4'h3,
    PID_NAK   = 4'hA,
    PID_DATA1 = 4'hB,
    PID_STALL = 4'hE
  } pid_t;

  localparam logic [2:0] PKT_DATA0 = 3'd1;
  localparam logic [2:0] PKT_DATA1 = 3'd2;
  localparam logic [2:0] PKT_ACK   = 3'd3;
  localparam logic [2:0] PKT_NAK   = 3'd4;
  localparam logic [2:0] PKT_STALL = 3'd5;

  localparam logic [7:0]  SYNC_BYTE  = 8'h80;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PID,
    DATA,
    CRC_LO,
    CRC_HI,
    DONE
  } state_t;

  function automatic logic pkt_is_data(input logic [2:0] code);
    return (code == PKT_DATA0) || (code == PKT_DATA1);
  endfunction

  function automatic logic pkt_is_valid(input logic [2:0] code);
    return (code >= PKT_DATA0) && (code <= PKT_STALL);
  endfunction

  function automatic pid_t pkt_pid(input logic [2:0] code);
    case (code)
      PKT_DATA0: return PID_DATA0;
      PKT_DATA1: return PID_DATA1;
      PKT_NAK:   return PID_NAK;
      PKT_STALL: return PID_STALL;
      default:   return PID_ACK;
    endcase
  endfunction

  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// USB CRC16 accumulator: LSB-first (reflected) form of polynomial 0x8005,
// one data byte per enabled cycle; clear reloads the initial value.
module usb_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  localparam logic [15:0] POLY_REFL = reflect16(CRC16_POLY);

  logic [15:0] crc_q;
  logic [15:0] crc_next;

  always_comb begin
    crc_next = crc_q;
    for (int unsigned i = 0; i < 8; i++) begin
      if (crc_next[0] ^ data[i]) crc_next = (crc_next >> 1) ^ POLY_REFL;
      else                       crc_next = crc_next >> 1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      crc_q <= CRC16_INIT;
    else if (clear)  crc_q <= CRC16_INIT;
    else if (enable) crc_q <= crc_next;
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_tx_sequencer.sv
// USB packet transmit sequencer: emits SYNC, PID, buffered payload and CRC16
// one byte per cycle toward the packet compiler.
module usb_tx_sequencer #(
  parameter int unsigned MAX_DATA = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_data,
  output logic       get_tx_data,
  output logic [7:0] tx_byte,  // the packet-compiler byte; 'byte' is a reserved word
  output logic       byte_valid,
  output logic       TX_Transfer_Active,
  output logic [9:0] packet_size_TX,
  output logic       tx_done,
  output logic       tx_error
);
  import usb_tx_pkg::*;

  localparam logic [7:0] MAX_N = 8'(MAX_DATA);

  state_t      state_q, state_d;
  logic [2:0]  pkt_q;
  logic [6:0]  n_q;
  logic [6:0]  cnt_q;
  logic [9:0]  size_q;
  logic        err_q;
  logic        accept, reject;
  logic        crc_clr, crc_en;
  logic        active;
  logic [15:0] crc;
  logic [3:0]  pid_bits;
  logic        req_ok;

  assign pid_bits = pkt_pid(pkt_q);
  assign req_ok   = pkt_is_valid(tx_packet) &&
                    !(pkt_is_data(tx_packet) && ({1'b0, buffer_occupancy} > MAX_N));

  usb_crc16 u_crc (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (crc_clr),
    .enable (crc_en),
    .data   (tx_data),
    .crc    (crc)
  );

  always_comb begin
    state_d     = state_q;
    tx_byte     = '0;
    active      = 1'b0;
    get_tx_data = 1'b0;
    tx_done     = 1'b0;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;
    accept      = 1'b0;
    reject      = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          if (req_ok) begin
            accept  = 1'b1;
            crc_clr = 1'b1;
            state_d = SYNC;
          end else begin
            reject = 1'b1;
          end
        end
      end
      SYNC: begin
        active  = 1'b1;
        tx_byte = SYNC_BYTE;
        state_d = PID;
      end
      PID: begin
        active  = 1'b1;
        tx_byte = {~pid_bits, pid_bits};
        if (!pkt_is_data(pkt_q)) state_d = DONE;
        else if (n_q != '0)      state_d = DATA;
        else                     state_d = CRC_LO;
      end
      DATA: begin
        active      = 1'b1;
        tx_byte     = tx_data;
        get_tx_data = 1'b1;
        crc_en      = 1'b1;
        if (cnt_q == n_q - 7'd1) state_d = CRC_LO;
      end
      CRC_LO: begin
        active  = 1'b1;
        tx_byte = ~crc[7:0];
        state_d = CRC_HI;
      end
      CRC_HI: begin
        active  = 1'b1;
        tx_byte = ~crc[15:8];
        state_d = DONE;
      end
      DONE: begin
        tx_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= reject;
      if (accept) begin
        pkt_q  <= tx_packet;
        n_q    <= pkt_is_data(tx_packet) ? buffer_occupancy : '0;
        cnt_q  <= '0;
        size_q <= '0;
      end else begin
        if (active)          size_q <= size_q + 10'd8;
        if (state_q == DATA) cnt_q  <= cnt_q + 7'd1;
      end
    end
  end

  assign TX_Transfer_Active = active;
  assign byte_valid         = active;
  assign packet_size_TX     = size_q;
  assign tx_error           = err_q;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Scoreboard bench for usb_tx_sequencer: stimulus pushes expected bytes, sizes,
// done/error timing; a negedge monitor pops and compares against the DUT.
module tb_usb_tx_sequencer;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [2:0] tx_packet = '0;
  logic [6:0] buffer_occupancy = '0;
  logic [7:0] tx_data;
  logic       get_tx_data;
  logic [7:0] tx_byte;
  logic       byte_valid;
  logic       TX_Transfer_Active;
  logic [9:0] packet_size_TX;
  logic       tx_done;
  logic       tx_error;

  usb_tx_sequencer #(.MAX_DATA(64)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_start           (tx_start),
    .tx_packet          (tx_packet),
    .buffer_occupancy   (buffer_occupancy),
    .tx_data            (tx_data),
    .get_tx_data        (get_tx_data),
    .tx_byte            (tx_byte),
    .byte_valid         (byte_valid),
    .TX_Transfer_Active (TX_Transfer_Active),
    .packet_size_TX     (packet_size_TX),
    .tx_done            (tx_done),
    .tx_error           (tx_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int head = 0;
  int gets_seen = 0;
  int obs_done = 0;
  int exp_done_total = 0;
  logic [7:0] mem [0:4095];

  logic [7:0] exp_bytes[$];
  int         exp_done_cyc[$];
  int         exp_size[$];
  int         exp_gets[$];
  int         exp_err_cyc[$];

  assign tx_data = mem[head % 4096];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (get_tx_data) head <= head + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s got=%0h expected=nothing (cycle %0d)", name, act, cyc);
  endtask

  // Reference CRC: MSB-first division over bit-reversed input, result reflected back.
  function automatic logic [15:0] ref_crc(input logic [7:0] d[$]);
    logic [15:0] r;
    logic [15:0] o;
    logic fb;
    r = 16'hFFFF;
    foreach (d[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = r[15] ^ d[k][b];
        r  = r << 1;
        if (fb) r = r ^ 16'h8005;
      end
    end
    for (int b = 0; b < 16; b++) o[b] = r[15-b];
    return ~o;
  endfunction

  function automatic logic [7:0] ref_pid(input logic [2:0] code);
    case (code)
      3'd1: return 8'hC3;
      3'd2: return 8'h4B;
      3'd3: return 8'hD2;
      3'd4: return 8'h5A;
      default: return 8'h1E;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!n_rst) begin
      gets_seen = 0;
    end else begin
      check("valid_eq_active", byte_valid, TX_Transfer_Active);
      if (byte_valid) begin
        if (exp_bytes.size() == 0) fail_unexpected("byte_unexpected", tx_byte);
        else check("byte", tx_byte, exp_bytes.pop_front());
      end else begin
        check("byte_zero_when_invalid", tx_byte, 0);
      end
      if (get_tx_data) gets_seen++;
      if (tx_done) begin
        obs_done++;
        if (exp_done_cyc.size() == 0) fail_unexpected("done_unexpected", cyc);
        else begin
          check("done_latency", cyc, exp_done_cyc.pop_front());
          check("packet_size", packet_size_TX, exp_size.pop_front());
          check("get_count", gets_seen, exp_gets.pop_front());
        end
        gets_seen = 0;
      end
      if (tx_error) begin
        if (exp_err_cyc.size() == 0) fail_unexpected("error_unexpected", cyc);
        else check("error_cycle", cyc, exp_err_cyc.pop_front());
      end
    end
  end

  task automatic send(input logic [2:0] code, input int n, input bit ramp);
    logic [7:0] d[$];
    bit is_data;
    bit ok;
    int base;
    @(posedge clk); #1;
    base = head;
    for (int i = 0; i < n; i++) begin
      mem[(base + i) % 4096] = ramp ? 8'(i) : 8'($urandom);
      d.push_back(mem[(base + i) % 4096]);
    end
    is_data = (code == 3'd1) || (code == 3'd2);
    ok = (code >= 3'd1) && (code <= 3'd5) && !(is_data && n > 64);
    tx_start = 1'b1;
    tx_packet = code;
    buffer_occupancy = 7'(n);
    if (ok) begin
      logic [15:0] c;
      int len;
      len = is_data ? n + 4 : 2;
      exp_bytes.push_back(8'h80);
      exp_bytes.push_back(ref_pid(code));
      if (is_data) begin
        c = ref_crc(d);
        foreach (d[k]) exp_bytes.push_back(d[k]);
        exp_bytes.push_back(c[7:0]);
        exp_bytes.push_back(c[15:8]);
      end
      exp_size.push_back(8 * len);
      exp_done_cyc.push_back(cyc + len + 1);
      exp_gets.push_back(is_data ? n : 0);
      exp_done_total++;
    end else begin
      exp_err_cyc.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    tx_start = 1'b0;
    tx_packet = 3'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_bytes.size() != 0 || exp_done_cyc.size() != 0 || exp_err_cyc.size() != 0) && k < 300) begin
      @(posedge clk); #1;
      buffer_occupancy = 7'($urandom_range(0, 127));
      k++;
    end
    if (k >= 300) fail_unexpected("timeout_waiting_for_packet", k);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_get"},    get_tx_data, 0);
    check({tag, "_byte"},   tx_byte, 0);
    check({tag, "_valid"},  byte_valid, 0);
    check({tag, "_active"}, TX_Transfer_Active, 0);
    check({tag, "_size"},   packet_size_TX, 0);
    check({tag, "_done"},   tx_done, 0);
    check({tag, "_error"},  tx_error, 0);
  endtask

  initial begin
    int base;
    int k;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;

    send(3'd3, 0, 1'b0);  wait_idle();     // ACK
    send(3'd1, 0, 1'b0);  wait_idle();     // DATA0 empty
    send(3'd2, 64, 1'b1); wait_idle();     // DATA1 full ramp
    send(3'd0, 0, 1'b0);  wait_idle();     // invalid code
    send(3'd1, 65, 1'b0); wait_idle();     // oversize

    // Reset while the 11th of 20 payload bytes is on the bus
    base = head;
    send(3'd2, 20, 1'b0);
    k = 0;
    while (head != base + 10 && k < 100) begin @(posedge clk); #1; k++; end
    if (k >= 100) fail_unexpected("timeout_reaching_byte10", head - base);
    n_rst = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_bytes.delete(); exp_done_cyc.delete(); exp_size.delete(); exp_gets.delete();
    exp_done_total--;
    @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_pops_after_reset", head - base, 10);
    send(3'd4, 0, 1'b0); wait_idle();      // NAK after reset

    // Second request during the PID of a STALL
    send(3'd5, 0, 1'b0);
    @(posedge clk); #1;
    tx_start = 1'b1;
    tx_packet = 3'd1;
    buffer_occupancy = 7'd5;
    @(posedge clk); #1;
    tx_start = 1'b0;
    wait_idle();

    for (int i = 0; i < 24; i++) begin
      logic [2:0] code;
      code = 3'($urandom_range(0, 7));
      send(code, $urandom_range(0, 70), 1'b0);
      wait_idle();
    end

    check("done_total", obs_done, exp_done_total);
    check("queues_drained", exp_bytes.size() + exp_err_cyc.size() + exp_done_cyc.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
